nibble_serial_adder: RTL

Multi-cycle WIDTH-bit adder/subtractor that processes one 4-bit nibble per clock through a 4-bit carry-lookahead slice. The slice takes generate a&b, propagate a|b and a carry-in, and produces c1, c2, c3 and co. This block feeds that slice one nibble pair per cycle, registers its carry-out for the next nibble, and assembles the sum. It sits between the datapath operand registers and the result register, trading latency for area against a full parallel CLA chain.

---
 rtl/nibble_serial_adder_if.sv | 34 +++
 rtl/nibble_serial_adder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_if.sv
// ============================================================================
// Module   : nibble_serial_adder_if
// Purpose  : Request/result bundle between the operand registers and the
//            nibble-serial adder/subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nibble_serial_adder_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    modport master (
        output start, op_sub, a, b, ci,
        input  busy, done, s, co, ovf
    );

    modport slave (
        input  start, op_sub, a, b, ci,
        output busy, done, s, co, ovf
    );
endinterface

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ============================================================================
// Module   : nibble_serial_adder
// Purpose  : WIDTH-bit add/subtract, one nibble per clock through a 4-bit
//            carry-lookahead slice with a registered inter-nibble carry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    nibble_serial_adder_if.slave bus
);

    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_s;
    logic               r_co;
    logic               r_ovf;

    logic [IDX_W+1:0]   w_base;
    logic [3:0]         w_na;
    logic [3:0]         w_nb;
    logic [3:0]         w_g;
    logic [3:0]         w_p;
    logic [3:0]         w_c;
    logic               w_co;
    logic [3:0]         w_sum;

    assign w_last = (r_idx == C_LAST_IDX);

    // Start is only honoured from IDLE or DONE; during RUN it is dropped.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Carry-lookahead slice for the current nibble.
    always_comb begin
        w_base = {r_idx, 2'b00};
        w_na   = r_a[w_base +: 4];
        w_nb   = r_b[w_base +: 4];
        w_g    = w_na & w_nb;
        w_p    = w_na | w_nb;
        w_c[0] = r_carry;
        w_c[1] = w_g[0] | (w_p[0] & r_carry);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & r_carry);
        w_co   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
        w_sum  = w_na ^ w_nb ^ w_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtraction becomes a + ~b + 1; ci is ignored in that case.
            r_a     <= bus.a;
            r_b     <= bus.b ^ {WIDTH{bus.op_sub}};
            r_carry <= bus.op_sub | bus.ci;
            r_idx   <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_s[w_base +: 4] <= w_sum;
            r_carry          <= w_co;
            if (w_last) begin
                r_idx <= '0;
                r_co  <= w_co;
                r_ovf <= w_c[3] ^ w_co;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign bus.busy = (r_state == ST_RUN);
    assign bus.done = (r_state == ST_DONE);
    assign bus.s    = r_s;
    assign bus.co   = r_co;
    assign bus.ovf  = r_ovf;

endmodule

`default_nettype wire
